// File: rtl/wb_register_unit.sv
// rtl/wb_register_unit.sv - writeback select merged with the 32x32 integer register file
module wb_register_unit #(
    parameter int          XLEN    = 32,
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] incrementPCIn,
    input  logic [XLEN-1:0] ALUResIn,
    input  logic [XLEN-1:0] DMDataRdIn,
    input  logic [4:0]      rdIn,
    input  logic [1:0]      ru_data_srcIn,
    input  logic            ru_wrIn,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] ru_rs1,
    output logic [XLEN-1:0] ru_rs2,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     wb_count
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_DMEM = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    // x0 has no storage; entries 1..31 only
    logic [XLEN-1:0] regs [1:31];
    logic            commit;

    always_comb begin
        wb_data = '0;
        case (ru_data_srcIn)
            SRC_ALU:  wb_data = ALUResIn;
            SRC_DMEM: wb_data = DMDataRdIn;
            SRC_PC4:  wb_data = incrementPCIn;
            default:  wb_data = '0;
        endcase
    end

    assign commit = ru_wrIn && (rdIn != 5'd0) && (ru_data_srcIn != 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= (i == 2) ? SP_INIT[XLEN-1:0] : '0;
            end
            wb_count <= '0;
        end else if (commit) begin
            regs[rdIn] <= wb_data;
            wb_count   <= wb_count + 32'd1;
        end
    end

    // Bypass stays live during reset so decode sees the value being presented
    always_comb begin
        ru_rs1 = '0;
        if (rs1 != 5'd0) begin
            ru_rs1 = (commit && rdIn == rs1) ? wb_data : regs[rs1];
        end
    end

    always_comb begin
        ru_rs2 = '0;
        if (rs2 != 5'd0) begin
            ru_rs2 = (commit && rdIn == rs2) ? wb_data : regs[rs2];
        end
    end

endmodule

// File: tb/tb_wb_register_unit.sv
// tb/tb_wb_register_unit.sv - randomized self-checking bench for wb_register_unit
module tb_wb_register_unit;

    localparam logic [31:0] SP = 32'h0000_3FFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc4, alu, dm;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  src;
    logic        wr;
    logic [31:0] ru_rs1, ru_rs2, wb_data, wb_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] mregs [32];
    logic [31:0] mcount;

    always #5 clk = ~clk;

    wb_register_unit dut (
        .clk(clk), .rst_n(rst_n),
        .incrementPCIn(pc4), .ALUResIn(alu), .DMDataRdIn(dm),
        .rdIn(rd), .ru_data_srcIn(src), .ru_wrIn(wr),
        .rs1(rs1), .rs2(rs2),
        .ru_rs1(ru_rs1), .ru_rs2(ru_rs2),
        .wb_data(wb_data), .wb_count(wb_count)
    );

    function automatic logic [31:0] m_wb();
        case (src)
            2'd0:    return alu;
            2'd1:    return dm;
            2'd2:    return pc4;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_commit();
        return wr && rd != 0 && src != 2'd3;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (m_commit() && rd == a) return m_wb();
        return mregs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mregs[2] = SP;
        mcount = 32'h0;
    endtask

    task automatic idle();
        wr = 0; src = 0; rd = 0; alu = 0; dm = 0; pc4 = 0;
    endtask

    // Advance one clock; inputs are changed 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        if (rst_n && m_commit()) begin
            mregs[rd] = m_wb();
            mcount = mcount + 1;
        end
        #2;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        wr = 1; src = 0; rd = r; alu = v;
        tick();
        idle();
    endtask

    task automatic test_reset();
        write_reg(5'd1, 32'h5);
        write_reg(5'd2, 32'h6);
        #1 rst_n = 0;
        model_reset();
        #1;
        for (int r = 0; r < 32; r++) begin
            rs1 = r[4:0]; rs2 = 5'(31 - r);
            #1;
            checks++;
            if (ru_rs1 !== mregs[r]) begin
                failures++;
                $display("FAIL reset_rs1 x%0d got=%h exp=%h", r, ru_rs1, mregs[r]);
            end
            checks++;
            if (ru_rs2 !== mregs[31-r]) begin
                failures++;
                $display("FAIL reset_rs2 x%0d got=%h exp=%h", 31 - r, ru_rs2, mregs[31-r]);
            end
        end
        checks++;
        if (wb_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_count got=%h exp=0", wb_count);
        end
        // bypass during reset, then commit lost on an edge while held in reset
        wr = 1; src = 0; rd = 4; alu = 32'h55; rs1 = 4;
        #1;
        checks++;
        if (ru_rs1 !== 32'h55) begin
            failures++;
            $display("FAIL reset_bypass got=%h exp=00000055", ru_rs1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ru_rs1 !== 32'h0 || wb_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_commit_lost x4=%h cnt=%h exp=0/0", ru_rs1, wb_count);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_src_select();
        logic [31:0] exp_v [3];
        logic [31:0] base;
        exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33;
        base = mcount;
        for (int s = 0; s < 3; s++) begin
            wr = 1; rd = 5; src = s[1:0]; alu = 32'h11; dm = 32'h22; pc4 = 32'h33;
            #1;
            checks++;
            if (wb_data !== exp_v[s]) begin
                failures++;
                $display("FAIL src_wb_data sel=%0d got=%h exp=%h", s, wb_data, exp_v[s]);
            end
            tick();
            idle(); rs1 = 5;
            #1;
            checks++;
            if (ru_rs1 !== exp_v[s]) begin
                failures++;
                $display("FAIL src_x5 sel=%0d got=%h exp=%h", s, ru_rs1, exp_v[s]);
            end
        end
        checks++;
        if (wb_count !== base + 32'd3) begin
            failures++;
            $display("FAIL src_count got=%h exp=%h", wb_count, base + 32'd3);
        end
    endtask

    task automatic test_no_write();
        logic [31:0] base;
        write_reg(5'd7, 32'h77);
        base = mcount;
        wr = 1; rd = 0; src = 0; alu = 32'hDEAD; rs1 = 0; rs2 = 0;
        #1;
        checks++;
        if (ru_rs1 !== 32'h0 || ru_rs2 !== 32'h0) begin
            failures++;
            $display("FAIL x0_read got=%h/%h exp=0", ru_rs1, ru_rs2);
        end
        tick();
        checks++;
        if (wb_count !== base) begin
            failures++;
            $display("FAIL x0_count got=%h exp=%h", wb_count, base);
        end
        wr = 1; rd = 7; src = 2'b11; alu = 32'hBAD; dm = 32'hBAD; pc4 = 32'hBAD; rs1 = 7;
        #1;
        checks++;
        if (ru_rs1 !== 32'h77 || wb_data !== 32'h0) begin
            failures++;
            $display("FAIL sel11_comb x7=%h wb=%h exp=00000077/0", ru_rs1, wb_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ru_rs1 !== 32'h77 || wb_count !== base) begin
            failures++;
            $display("FAIL sel11_commit x7=%h cnt=%h exp=00000077/%h", ru_rs1, wb_count, base);
        end
    endtask

    task automatic test_bypass();
        write_reg(5'd9, 32'h1234);
        wr = 1; rd = 9; src = 0; alu = 32'hCAFE; rs1 = 9; rs2 = 9;
        #1;
        checks++;
        if (ru_rs1 !== 32'hCAFE || ru_rs2 !== 32'hCAFE) begin
            failures++;
            $display("FAIL bypass got=%h/%h exp=0000cafe", ru_rs1, ru_rs2);
        end
        wr = 0;
        #1;
        checks++;
        if (ru_rs1 !== 32'h1234 || ru_rs2 !== 32'h1234) begin
            failures++;
            $display("FAIL bypass_off got=%h/%h exp=00001234", ru_rs1, ru_rs2);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        rs1 = 3;
        for (int v = 1; v <= 2; v++) begin
            wr = 1; rd = 3; src = 0; alu = v;
            #1;
            checks++;
            if (ru_rs1 !== 32'(v)) begin
                failures++;
                $display("FAIL b2b_cycle%0d got=%h exp=%h", v, ru_rs1, 32'(v));
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (ru_rs1 !== 32'h2) begin
            failures++;
            $display("FAIL b2b_final got=%h exp=00000002", ru_rs1);
        end
    endtask

    task automatic test_wrap();
        force dut.wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count;
        #1;
        mcount = 32'hFFFF_FFFF;
        checks++;
        if (wb_count !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_preload got=%h exp=ffffffff", wb_count);
        end
        write_reg(5'd10, 32'hA);
        checks++;
        if (wb_count !== 32'h0) begin
            failures++;
            $display("FAIL wrap got=%h exp=00000000", wb_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            wr = $urandom_range(0, 3) != 0;
            src = 2'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 31));
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            alu = $urandom; dm = $urandom; pc4 = $urandom;
            #1;
            checks++;
            if (wb_data !== m_wb() || ru_rs1 !== m_read(rs1) || ru_rs2 !== m_read(rs2)) begin
                failures++;
                $display("FAIL rand_read n=%0d wb=%h/%h rs1=%h/%h rs2=%h/%h",
                         n, wb_data, m_wb(), ru_rs1, m_read(rs1), ru_rs2, m_read(rs2));
            end
            tick();
            checks++;
            if (wb_count !== mcount) begin
                failures++;
                $display("FAIL rand_count n=%0d got=%h exp=%h", n, wb_count, mcount);
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 0; rs1 = 0; rs2 = 0;
        idle();
        model_reset();
        #12 rst_n = 1;
        #5;
        test_reset();
        #2;
        test_src_select();
        test_no_write();
        test_bypass();
        test_back_to_back();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/wb_register_unit.md
# wb_register_unit

Writeback-stage consumer of the MEM/WB pipeline register, merged with the 32×32-bit integer register file. It selects the writeback value (ALU result, data-memory read data, or PC+4) using the ru_data_src control from MEM/WB. It commits that value to rd on the clock edge and serves the decode stage's two combinational read ports. Same-cycle write-to-read bypass means decode never reads a stale value for an instruction retiring in WB.

## Interface
- XLEN, 32, data width of registers and all data ports
- SP_INIT, 32'h0000_3FFC, reset value of x2 (sp)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- incrementPCIn  input  32  PC+4 from MEM/WB
- ALUResIn  input  32  ALU result from MEM/WB
- DMDataRdIn  input  32  data-memory read data from MEM/WB
- rdIn  input  5  destination register from MEM/WB
- ru_data_srcIn  input  2  writeback source select from MEM/WB
- ru_wrIn  input  1  register write enable from MEM/WB
- rs1  input  5  read address A (decode stage)
- rs2  input  5  read address B (decode stage)
- ru_rs1  output  32  read data A (combinational)
- ru_rs2  output  32  read data B (combinational)
- wb_data  output  32  selected writeback value (combinational, for forwarding)
- wb_count  output  32  registered count of committed writes

## Operation
- Writeback select: ru_data_srcIn 2'b00 → ALUResIn; 2'b01 → DMDataRdIn; 2'b10 → incrementPCIn; 2'b11 → 32'h0, and the write is suppressed.
- Commit: on posedge clk, when ru_wrIn=1 and rdIn≠0 and ru_data_srcIn≠2'b11, regs[rdIn] ← wb_data, and wb_count increments by 1.
- Commits to rdIn=0 are discarded and do not increment wb_count.
- x0 always reads 32'h0. No storage for x0 is required.
- Reads:
  - ru_rs1 = (rs1==0) ? 0 : (commit-valid && rdIn==rs1) ? wb_data : regs[rs1].
  - ru_rs2 is the same with rs2.
  - Bypass takes priority over stored contents.
- Both read ports may address the same register and the same rd simultaneously; both get the bypassed value.
- wb_count wraps 32'hFFFF_FFFF → 0 with no flag.
- Reset (async, rst_n=0):
  - All registers clear to 0, except x2 ← SP_INIT.
  - wb_count ← 0.
  - Takes effect immediately, regardless of clk.
  - While rst_n=0, commits are blocked and reads return reset contents.
  - The bypass path is still combinationally active on the read outputs.
- Reset release: the first commit can occur on the first posedge with rst_n=1.

## Timing
- Write latency: 1 cycle. The value is visible in regs after the posedge, and visible through bypass in the same cycle it is presented.
- Read latency: 0 cycles (combinational from rs1/rs2, rdIn, ru_wrIn, ru_data_srcIn and the data inputs).
- wb_data is purely combinational from MEM/WB outputs. It carries no register stage.
- Reset mid-operation: an in-flight commit on the same edge on which rst_n is low is lost. The register holds its reset value.
- No handshake. The block accepts one writeback per cycle unconditionally. Stalls and bubbles arrive as ru_wrIn=0 from upstream.

## Test plan
- Reset: assert rst_n=0 mid-cycle → x1..x31 read 0 except x2=32'h0000_3FFC; wb_count=0, without waiting for a clk edge.
- Source select: rd=5, wr=1 with sel=00/01/10 and ALU=0x11, DM=0x22, PC+4=0x33 on three cycles → x5 reads 0x11, 0x22, 0x33 after each edge; wb_count=3.
- x0 and no-write cases:
  - rd=0, wr=1, ALU=0xDEAD → x0 reads 0 and wb_count is unchanged.
  - sel=11 with wr=1, rd=7 → x7 is unchanged.
- Bypass: rd=9, wr=1, ALU=0xCAFE, rs1=rs2=9 before the edge → ru_rs1=ru_rs2=0xCAFE in the same cycle; with wr=0, the old value is shown.
- Back-to-back: write x3=1, then x3=2 on consecutive cycles while rs1=3 → ru_rs1 shows 1 and then 2, each in its own cycle. Final x3=2.
- Counter wrap: force wb_count to 32'hFFFF_FFFF via 2^32−1 commits or backdoor, then one commit → wb_count=0.
